// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the UART transmitter and receiver:
//   ticks_per_bit() - clock cycles per serial bit for a clock/baud pair
//   START_BIT       - line level of a start bit
//   STOP_BIT        - line level of a stop bit
//   rx_state_t      - receiver frame-tracking states
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  function automatic int ticks_per_bit(input int clock_freq, input int baud_rate);
    return clock_freq / baud_rate;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for a single asynchronous input.
// Ports:
//   clock  - destination clock
//   reset  - synchronous, active-high reset (both flops load reset_value)
//   d      - asynchronous input
//   q      - synchronized output, two cycles behind d
// ---------------------------------------------------------------------------
module sync_2ff #(
  parameter logic reset_value = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta <= reset_value;
      q    <= reset_value;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
// UART receiver for start/width data bits (LSB first)/one stop bit frames.
// The line is sampled in the middle of each bit; completed words are
// offered on a valid/ready handshake through a one-word holding register.
// Ports:
//   clock         - system clock
//   reset         - synchronous, active-high reset
//   signal        - asynchronous serial line, idle high
//   data          - received word, stable while valid is high
//   valid         - data holds an unconsumed word
//   ready         - consumer takes data when valid && ready at a rising edge
//   framing_error - one-cycle pulse: stop bit was sampled low
//   overrun       - one-cycle pulse: a finished word was dropped because
//                   the holding register was still full
// ticks_per_bit (clock_freq / baud_rate) must be at least 4.
// ---------------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
#(
  parameter int width      = 8,
  parameter int baud_rate  = 9600,
  parameter int clock_freq = 460800
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             signal,
  output logic [width-1:0] data,
  output logic             valid,
  input  logic             ready,
  output logic             framing_error,
  output logic             overrun
);

  localparam int TICKS = ticks_per_bit(clock_freq, baud_rate);
  localparam int HALF  = TICKS / 2;
  localparam int CNT_W = $clog2(TICKS + 1);
  localparam int IDX_W = (width > 1) ? $clog2(width) : 1;

  // The tick counter starts at 0 on the cycle after a sample point, so a
  // compare against N-1 lands exactly N cycles after that point.
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(TICKS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(width - 1);

  logic             sync_signal;
  rx_state_t        state;
  logic [CNT_W-1:0] tick;
  logic [IDX_W-1:0] bit_idx;
  logic [width-1:0] shift_reg;
  logic             word_done;

  sync_2ff #(
    .reset_value(1'b1)
  ) u_line_sync (
    .clock(clock),
    .reset(reset),
    .d    (signal),
    .q    (sync_signal)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= WAIT_IDLE;
      tick          <= '0;
      bit_idx       <= '0;
      shift_reg     <= '0;
      word_done     <= 1'b0;
      data          <= '0;
      valid         <= 1'b0;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      framing_error <= 1'b0;
      overrun       <= 1'b0;
      word_done     <= 1'b0;

      // Holding register: a finished word loads if the register is empty or
      // is being emptied on this same edge; otherwise the new word is lost.
      if (word_done) begin
        if (!valid || ready) begin
          data  <= shift_reg;
          valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end

      // shift_reg is only rewritten in DATA, at least half a bit after the
      // next start edge, so a back-to-back frame cannot corrupt the word
      // being handed over during the word_done cycle.
      case (state)
        WAIT_IDLE: begin
          if (sync_signal == STOP_BIT) state <= IDLE;
        end

        IDLE: begin
          if (sync_signal == START_BIT) begin
            tick  <= '0;
            state <= START;
          end
        end

        START: begin
          if (tick == HALF_LAST) begin
            tick <= '0;
            if (sync_signal == START_BIT) begin
              bit_idx <= '0;
              state   <= DATA;
            end else begin
              state <= IDLE;
            end
          end else begin
            tick <= tick + 1'b1;
          end
        end

        DATA: begin
          if (tick == BIT_LAST) begin
            tick               <= '0;
            shift_reg[bit_idx] <= sync_signal;
            if (bit_idx == IDX_LAST) state <= STOP;
            else bit_idx <= bit_idx + 1'b1;
          end else begin
            tick <= tick + 1'b1;
          end
        end

        STOP: begin
          if (tick == BIT_LAST) begin
            tick <= '0;
            if (sync_signal == STOP_BIT) begin
              word_done <= 1'b1;
              state     <= IDLE;
            end else begin
              framing_error <= 1'b1;
              state         <= WAIT_IDLE;
            end
          end else begin
            tick <= tick + 1'b1;
          end
        end

        default: state <= WAIT_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
// Serial frames are driven onto the line; every word that should reach the
// consumer is queued when its frame starts, and a monitor pops and compares
// on each valid && ready handshake. Error pulses are counted by the monitor.
// ---------------------------------------------------------------------------
module tb_uart_rx;

  localparam int T = 48;
  localparam int H = T / 2;

  logic       clock = 1'b0;
  logic       reset;
  logic       signal;
  logic       ready;
  logic [7:0] data;
  logic       valid;
  logic       framing_error;
  logic       overrun;

  uart_rx #(
    .width     (8),
    .baud_rate (9600),
    .clock_freq(460800)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .signal       (signal),
    .data         (data),
    .valid        (valid),
    .ready        (ready),
    .framing_error(framing_error),
    .overrun      (overrun)
  );

  always #5 clock = ~clock;

  int         total = 0;
  int         bad = 0;
  int         rx_count = 0;
  int         fe_count = 0;
  int         ov_count = 0;
  int         cyc = 0;
  int         start_cyc = 0;
  int         latency = 0;
  logic       prev_valid = 1'b0;
  logic [7:0] exp_word;
  logic [7:0] sb[$];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, actual, actual,
               expected, expected);
    end
  endtask

  // Monitor: compares words at the handshake and counts error pulses.
  always @(negedge clock) begin
    if (!reset) begin
      if (valid && !prev_valid) latency = cyc - start_cyc;
      if (valid && ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_word: got 0x%0h expected no word", data);
        end else begin
          exp_word = sb.pop_front();
          checkOutput("word", int'(data), int'(exp_word));
          rx_count++;
        end
      end
      if (framing_error) fe_count++;
      if (overrun) ov_count++;
    end
    prev_valid = valid;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drives one complete frame; queues the word if it is expected to arrive.
  task automatic applyStimulus(input logic [7:0] word, input logic stop_bit,
                               input bit expect_word);
    if (expect_word) sb.push_back(word);
    signal    = 1'b0;
    start_cyc = cyc;
    repeat (T) tick();
    for (int i = 0; i < 8; i++) begin
      signal = word[i];
      repeat (T) tick();
    end
    signal = stop_bit;
    repeat (T) tick();
  endtask

  task automatic waitDrain(input string name);
    for (int i = 0; i < 30 * T && sb.size() != 0; i++) tick();
    checkOutput(name, sb.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset  = 1'b1;
    signal = 1'b1;
    ready  = 1'b1;
    repeat (2) tick();
    checkOutput("reset_valid", int'(valid), 0);
    checkOutput("reset_data", int'(data), 0);
    checkOutput("reset_framing_error", int'(framing_error), 0);
    checkOutput("reset_overrun", int'(overrun), 0);
    reset = 1'b0;
    repeat (4) tick();

    $display("[TB] test 1: frame 0xA5");
    latency = 0;
    applyStimulus(8'hA5, 1'b1, 1'b1);
    repeat (T) tick();
    waitDrain("drain_t1");
    checkOutput("t1_rx_count", rx_count, 1);
    checkOutput("t1_latency_window",
                int'(latency >= H + 9 * T + 2 && latency <= H + 9 * T + 5), 1);
    checkOutput("t1_framing_error", fe_count, 0);
    checkOutput("t1_overrun", ov_count, 0);

    $display("[TB] test 2: short glitch then frame 0x3C");
    signal = 1'b0;
    repeat (10) tick();
    signal = 1'b1;
    repeat (2 * T) tick();
    checkOutput("t2_no_word_from_glitch", rx_count, 1);
    applyStimulus(8'h3C, 1'b1, 1'b1);
    repeat (T) tick();
    waitDrain("drain_t2");
    checkOutput("t2_rx_count", rx_count, 2);

    $display("[TB] test 3: bad stop bit then frame 0x5A");
    applyStimulus(8'h3C, 1'b0, 1'b0);
    repeat (100) tick();
    signal = 1'b1;
    repeat (T) tick();
    checkOutput("t3_framing_error", fe_count, 1);
    checkOutput("t3_no_word_from_bad_frame", rx_count, 2);
    applyStimulus(8'h5A, 1'b1, 1'b1);
    repeat (T) tick();
    waitDrain("drain_t3");
    checkOutput("t3_rx_count", rx_count, 3);

    $display("[TB] test 4: overrun with ready low");
    ready = 1'b0;
    applyStimulus(8'h11, 1'b1, 1'b1);
    applyStimulus(8'h22, 1'b1, 1'b0);
    repeat (T) tick();
    checkOutput("t4_valid_held", int'(valid), 1);
    checkOutput("t4_data_held", int'(data), 8'h11);
    checkOutput("t4_overrun", ov_count, 1);
    ready = 1'b1;
    repeat (3) tick();
    waitDrain("drain_t4");
    checkOutput("t4_valid_dropped", int'(valid), 0);
    checkOutput("t4_rx_count", rx_count, 4);

    $display("[TB] test 5: back-to-back stream");
    for (int i = 0; i < 32; i++) applyStimulus(8'((i * 37 + 5) & 255), 1'b1, 1'b1);
    signal = 1'b1;
    repeat (T) tick();
    waitDrain("drain_t5");
    checkOutput("t5_rx_count", rx_count, 36);
    checkOutput("t5_framing_error", fe_count, 1);
    checkOutput("t5_overrun", ov_count, 1);

    $display("[TB] test 6: reset in the middle of frame 0xFF");
    signal = 1'b0;
    repeat (T) tick();
    signal = 1'b1;
    repeat (4 * T + H) tick();
    reset = 1'b1;
    repeat (2) tick();
    checkOutput("t6_reset_valid", int'(valid), 0);
    checkOutput("t6_reset_data", int'(data), 0);
    reset = 1'b0;
    repeat (5 * T - H - 2) tick();
    applyStimulus(8'h81, 1'b1, 1'b1);
    repeat (T) tick();
    waitDrain("drain_t6");
    checkOutput("t6_rx_count", rx_count, 37);
    checkOutput("t6_framing_error", fe_count, 1);
    checkOutput("t6_overrun", ov_count, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
